// File: rtl/iob_ddr_axi_arbiter_if.sv
// AXI4 bundle used for both arbiter slave ports and the shared master port.
// "master" drives requests and write data; "slave" drives readys and responses.
interface iob_ddr_axi_arbiter_if #(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ADDR_W = 30,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8
);
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [AXI_LEN_W-1:0]    awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [AXI_LEN_W-1:0]    arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;

  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/iob_ddr_axi_arbiter.sv
// Two-port AXI4 arbiter sharing one DDR AXI path. Write and read directions are
// granted independently, round-robin, one outstanding burst per direction.
module iob_ddr_axi_arbiter #(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ADDR_W = 30,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  iob_ddr_axi_arbiter_if.slave  s0_axi,
  iob_ddr_axi_arbiter_if.slave  s1_axi,
  iob_ddr_axi_arbiter_if.master m_axi,
  output logic [1:0]            wr_grant_o,
  output logic [1:0]            rd_grant_o
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wrState_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rdState_t;

  wrState_t   wrState_q;
  logic [1:0] wrGrant_q;
  logic       wrPtr_q;
  rdState_t   rdState_q;
  logic [1:0] rdGrant_q;
  logic       rdPtr_q;

  logic wrPick1_d, rdPick1_d;
  logic wAddrPh, wDataPh, wRespPh, rAddrPh, rDataPh;

  // Port 1 wins when it is the only requester or when the pointer prefers it.
  assign wrPick1_d = s1_axi.awvalid & (~s0_axi.awvalid | wrPtr_q);
  assign rdPick1_d = s1_axi.arvalid & (~s0_axi.arvalid | rdPtr_q);

  assign wAddrPh = (wrState_q == W_ADDR);
  assign wDataPh = (wrState_q == W_DATA);
  assign wRespPh = (wrState_q == W_RESP);
  assign rAddrPh = (rdState_q == R_ADDR);
  assign rDataPh = (rdState_q == R_DATA);

  assign wr_grant_o = wrGrant_q;
  assign rd_grant_o = rdGrant_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wrState_q <= W_IDLE;
      wrGrant_q <= 2'b00;
      wrPtr_q   <= 1'b0;
    end else begin
      case (wrState_q)
        W_IDLE: if (s0_axi.awvalid || s1_axi.awvalid) begin
          wrGrant_q <= wrPick1_d ? 2'b10 : 2'b01;
          wrState_q <= W_ADDR;
        end
        W_ADDR: if (m_axi.awvalid && m_axi.awready) wrState_q <= W_DATA;
        W_DATA: if (m_axi.wvalid && m_axi.wready && m_axi.wlast) wrState_q <= W_RESP;
        W_RESP: if (m_axi.bvalid && m_axi.bready) begin
          wrState_q <= W_IDLE;
          wrGrant_q <= 2'b00;
          wrPtr_q   <= wrGrant_q[0];
        end
        default: wrState_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdState_q <= R_IDLE;
      rdGrant_q <= 2'b00;
      rdPtr_q   <= 1'b0;
    end else begin
      case (rdState_q)
        R_IDLE: if (s0_axi.arvalid || s1_axi.arvalid) begin
          rdGrant_q <= rdPick1_d ? 2'b10 : 2'b01;
          rdState_q <= R_ADDR;
        end
        R_ADDR: if (m_axi.arvalid && m_axi.arready) rdState_q <= R_DATA;
        R_DATA: if (m_axi.rvalid && m_axi.rready && m_axi.rlast) begin
          rdState_q <= R_IDLE;
          rdGrant_q <= 2'b00;
          rdPtr_q   <= rdGrant_q[0];
        end
        default: rdState_q <= R_IDLE;
      endcase
    end
  end

  // Write address: payload follows the grant, valid/ready only in the address phase.
  assign m_axi.awid    = wrGrant_q[1] ? s1_axi.awid    : wrGrant_q[0] ? s0_axi.awid    : {AXI_ID_W{1'b0}};
  assign m_axi.awaddr  = wrGrant_q[1] ? s1_axi.awaddr  : wrGrant_q[0] ? s0_axi.awaddr  : {AXI_ADDR_W{1'b0}};
  assign m_axi.awlen   = wrGrant_q[1] ? s1_axi.awlen   : wrGrant_q[0] ? s0_axi.awlen   : {AXI_LEN_W{1'b0}};
  assign m_axi.awsize  = wrGrant_q[1] ? s1_axi.awsize  : wrGrant_q[0] ? s0_axi.awsize  : '0;
  assign m_axi.awburst = wrGrant_q[1] ? s1_axi.awburst : wrGrant_q[0] ? s0_axi.awburst : '0;
  assign m_axi.awlock  = wrGrant_q[1] ? s1_axi.awlock  : wrGrant_q[0] ? s0_axi.awlock  : 1'b0;
  assign m_axi.awcache = wrGrant_q[1] ? s1_axi.awcache : wrGrant_q[0] ? s0_axi.awcache : '0;
  assign m_axi.awprot  = wrGrant_q[1] ? s1_axi.awprot  : wrGrant_q[0] ? s0_axi.awprot  : '0;
  assign m_axi.awqos   = wrGrant_q[1] ? s1_axi.awqos   : wrGrant_q[0] ? s0_axi.awqos   : '0;
  assign m_axi.awvalid = wAddrPh & ((wrGrant_q[0] & s0_axi.awvalid) | (wrGrant_q[1] & s1_axi.awvalid));
  assign s0_axi.awready = wAddrPh & wrGrant_q[0] & m_axi.awready;
  assign s1_axi.awready = wAddrPh & wrGrant_q[1] & m_axi.awready;

  // Write data is held off until the owner's AW has been accepted.
  assign m_axi.wdata  = wrGrant_q[1] ? s1_axi.wdata : wrGrant_q[0] ? s0_axi.wdata : {AXI_DATA_W{1'b0}};
  assign m_axi.wstrb  = wrGrant_q[1] ? s1_axi.wstrb : wrGrant_q[0] ? s0_axi.wstrb : '0;
  assign m_axi.wlast  = wrGrant_q[1] ? s1_axi.wlast : wrGrant_q[0] ? s0_axi.wlast : 1'b0;
  assign m_axi.wvalid = wDataPh & ((wrGrant_q[0] & s0_axi.wvalid) | (wrGrant_q[1] & s1_axi.wvalid));
  assign s0_axi.wready = wDataPh & wrGrant_q[0] & m_axi.wready;
  assign s1_axi.wready = wDataPh & wrGrant_q[1] & m_axi.wready;

  assign m_axi.bready  = wRespPh & ((wrGrant_q[0] & s0_axi.bready) | (wrGrant_q[1] & s1_axi.bready));
  assign s0_axi.bvalid = wRespPh & wrGrant_q[0] & m_axi.bvalid;
  assign s1_axi.bvalid = wRespPh & wrGrant_q[1] & m_axi.bvalid;
  assign s0_axi.bid    = wrGrant_q[0] ? m_axi.bid   : {AXI_ID_W{1'b0}};
  assign s1_axi.bid    = wrGrant_q[1] ? m_axi.bid   : {AXI_ID_W{1'b0}};
  assign s0_axi.bresp  = wrGrant_q[0] ? m_axi.bresp : 2'b00;
  assign s1_axi.bresp  = wrGrant_q[1] ? m_axi.bresp : 2'b00;

  assign m_axi.arid    = rdGrant_q[1] ? s1_axi.arid    : rdGrant_q[0] ? s0_axi.arid    : {AXI_ID_W{1'b0}};
  assign m_axi.araddr  = rdGrant_q[1] ? s1_axi.araddr  : rdGrant_q[0] ? s0_axi.araddr  : {AXI_ADDR_W{1'b0}};
  assign m_axi.arlen   = rdGrant_q[1] ? s1_axi.arlen   : rdGrant_q[0] ? s0_axi.arlen   : {AXI_LEN_W{1'b0}};
  assign m_axi.arsize  = rdGrant_q[1] ? s1_axi.arsize  : rdGrant_q[0] ? s0_axi.arsize  : '0;
  assign m_axi.arburst = rdGrant_q[1] ? s1_axi.arburst : rdGrant_q[0] ? s0_axi.arburst : '0;
  assign m_axi.arlock  = rdGrant_q[1] ? s1_axi.arlock  : rdGrant_q[0] ? s0_axi.arlock  : 1'b0;
  assign m_axi.arcache = rdGrant_q[1] ? s1_axi.arcache : rdGrant_q[0] ? s0_axi.arcache : '0;
  assign m_axi.arprot  = rdGrant_q[1] ? s1_axi.arprot  : rdGrant_q[0] ? s0_axi.arprot  : '0;
  assign m_axi.arqos   = rdGrant_q[1] ? s1_axi.arqos   : rdGrant_q[0] ? s0_axi.arqos   : '0;
  assign m_axi.arvalid = rAddrPh & ((rdGrant_q[0] & s0_axi.arvalid) | (rdGrant_q[1] & s1_axi.arvalid));
  assign s0_axi.arready = rAddrPh & rdGrant_q[0] & m_axi.arready;
  assign s1_axi.arready = rAddrPh & rdGrant_q[1] & m_axi.arready;

  // Read data returns to the read owner only; the other port sees zeros.
  assign m_axi.rready  = rDataPh & ((rdGrant_q[0] & s0_axi.rready) | (rdGrant_q[1] & s1_axi.rready));
  assign s0_axi.rvalid = rDataPh & rdGrant_q[0] & m_axi.rvalid;
  assign s1_axi.rvalid = rDataPh & rdGrant_q[1] & m_axi.rvalid;
  assign s0_axi.rid    = rdGrant_q[0] ? m_axi.rid   : {AXI_ID_W{1'b0}};
  assign s1_axi.rid    = rdGrant_q[1] ? m_axi.rid   : {AXI_ID_W{1'b0}};
  assign s0_axi.rdata  = rdGrant_q[0] ? m_axi.rdata : {AXI_DATA_W{1'b0}};
  assign s1_axi.rdata  = rdGrant_q[1] ? m_axi.rdata : {AXI_DATA_W{1'b0}};
  assign s0_axi.rresp  = rdGrant_q[0] ? m_axi.rresp : 2'b00;
  assign s1_axi.rresp  = rdGrant_q[1] ? m_axi.rresp : 2'b00;
  assign s0_axi.rlast  = rdGrant_q[0] ? m_axi.rlast : 1'b0;
  assign s1_axi.rlast  = rdGrant_q[1] ? m_axi.rlast : 1'b0;
endmodule

// File: tb/tb_iob_ddr_axi_arbiter.sv
// Directed bench for the two-port DDR AXI arbiter: grants, round robin,
// concurrent write/read, backpressure ordering and asynchronous reset.
module tb_iob_ddr_axi_arbiter;
  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [1:0] wr_grant_o;
  logic [1:0] rd_grant_o;
  int         checkCount = 0;
  int         passCount = 0;

  iob_ddr_axi_arbiter_if s0 ();
  iob_ddr_axi_arbiter_if s1 ();
  iob_ddr_axi_arbiter_if m ();

  iob_ddr_axi_arbiter dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .s0_axi     (s0),
    .s1_axi     (s1),
    .m_axi      (m),
    .wr_grant_o (wr_grant_o),
    .rd_grant_o (rd_grant_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge, so outputs are sampled well away from posedge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [63:0] pick(input int p, input logic [63:0] a, input logic [63:0] b);
    return (p == 0) ? a : b;
  endfunction

  task automatic setAw(input int p, input logic v, input logic [29:0] addr, input logic [7:0] len, input logic [3:0] id);
    if (p == 0) begin s0.awvalid = v; s0.awaddr = addr; s0.awlen = len; s0.awid = id; end
    else        begin s1.awvalid = v; s1.awaddr = addr; s1.awlen = len; s1.awid = id; end
  endtask

  task automatic setW(input int p, input logic v, input logic [31:0] data, input logic last);
    if (p == 0) begin s0.wvalid = v; s0.wdata = data; s0.wlast = last; end
    else        begin s1.wvalid = v; s1.wdata = data; s1.wlast = last; end
  endtask

  task automatic setAr(input int p, input logic v, input logic [29:0] addr, input logic [7:0] len, input logic [3:0] id);
    if (p == 0) begin s0.arvalid = v; s0.araddr = addr; s0.arlen = len; s0.arid = id; end
    else        begin s1.arvalid = v; s1.araddr = addr; s1.arlen = len; s1.arid = id; end
  endtask

  task automatic initInputs();
    setAw(0, 0, 0, 0, 0); setAw(1, 0, 0, 0, 0);
    setW(0, 0, 0, 0);     setW(1, 0, 0, 0);
    setAr(0, 0, 0, 0, 0); setAr(1, 0, 0, 0, 0);
    s0.awsize = 3'd2; s1.awsize = 3'd1; s0.arsize = 3'd2; s1.arsize = 3'd1;
    s0.awburst = 2'd1; s1.awburst = 2'd1; s0.arburst = 2'd1; s1.arburst = 2'd1;
    s0.awlock = 0; s1.awlock = 0; s0.arlock = 0; s1.arlock = 0;
    s0.awcache = 0; s1.awcache = 0; s0.arcache = 0; s1.arcache = 0;
    s0.awprot = 0; s1.awprot = 0; s0.arprot = 0; s1.arprot = 0;
    s0.awqos = 0; s1.awqos = 0; s0.arqos = 0; s1.arqos = 0;
    s0.wstrb = 4'hF; s1.wstrb = 4'h3;
    s0.bready = 1; s1.bready = 1; s0.rready = 1; s1.rready = 1;
    m.awready = 1; m.wready = 1; m.arready = 1;
    m.bvalid = 0; m.bid = 0; m.bresp = 0;
    m.rvalid = 0; m.rid = 0; m.rdata = 0; m.rresp = 0; m.rlast = 0;
  endtask

  // Entered on the falling edge where port p owns W_ADDR; returns once back in idle.
  task automatic writeTxn(input int p, input int beats, input logic [29:0] addr, input logic [31:0] step, input string tag);
    logic [31:0] d;
    #1;
    checkOutput({tag, " wgrant"}, wr_grant_o, (p == 0) ? 2'b01 : 2'b10);
    checkOutput({tag, " awvalid"}, m.awvalid, 1'b1);
    checkOutput({tag, " awaddr"}, m.awaddr, addr);
    checkOutput({tag, " awsize"}, m.awsize, (p == 0) ? 3'd2 : 3'd1);
    checkOutput({tag, " awready own"}, pick(p, s0.awready, s1.awready), 1'b1);
    checkOutput({tag, " awready other"}, pick(1 - p, s0.awready, s1.awready), 1'b0);
    checkOutput({tag, " wready pre-aw"}, pick(p, s0.wready, s1.wready), 1'b0);
    applyStimulus(1);
    setAw(p, 0, 0, 0, 0);
    for (int i = 0; i < beats; i++) begin
      d = step * (i + 1);
      setW(p, 1, d, i == beats - 1);
      #1;
      checkOutput({tag, " wdata"}, m.wdata, d);
      checkOutput({tag, " wlast"}, m.wlast, i == beats - 1);
      checkOutput({tag, " wstrb"}, m.wstrb, (p == 0) ? 4'hF : 4'h3);
      checkOutput({tag, " wready other"}, pick(1 - p, s0.wready, s1.wready), 1'b0);
      applyStimulus(1);
    end
    setW(p, 0, 0, 0);
    m.bvalid = 1; m.bid = 4'(p + 7); m.bresp = 2'b00;
    #1;
    checkOutput({tag, " bvalid own"}, pick(p, s0.bvalid, s1.bvalid), 1'b1);
    checkOutput({tag, " bvalid other"}, pick(1 - p, s0.bvalid, s1.bvalid), 1'b0);
    checkOutput({tag, " bid"}, pick(p, s0.bid, s1.bid), 64'(p + 7));
    checkOutput({tag, " bready"}, m.bready, 1'b1);
    applyStimulus(1);
    m.bvalid = 0;
    #1;
    checkOutput({tag, " wgrant idle"}, wr_grant_o, 2'b00);
  endtask

  logic [31:0] wGot[$];
  logic [31:0] rGot[$];
  int          wi, ri;

  initial begin
    rstn_i = 1'b0;
    initInputs();
    setAw(0, 1, 30'h40, 8'd0, 4'd1);
    setAr(1, 1, 30'h80, 8'd0, 4'd1);
    #12;
    checkOutput("reset wgrant", wr_grant_o, 2'b00);
    checkOutput("reset rgrant", rd_grant_o, 2'b00);
    checkOutput("reset awvalid", m.awvalid, 1'b0);
    checkOutput("reset arvalid", m.arvalid, 1'b0);
    checkOutput("reset bready", m.bready, 1'b0);
    checkOutput("reset rready", m.rready, 1'b0);
    checkOutput("reset s0 awready", s0.awready, 1'b0);
    checkOutput("reset s1 arready", s1.arready, 1'b0);
    setAw(0, 0, 0, 0, 0);
    setAr(1, 0, 0, 0, 0);
    applyStimulus(1);
    rstn_i = 1'b1;

    $display("[TB] simultaneous writes after reset");
    applyStimulus(1);
    setAw(0, 1, 30'h100, 8'd0, 4'd2);
    setAw(1, 1, 30'h200, 8'd0, 4'd3);
    setW(1, 1, 32'hDEAD_BEEF, 1'b1);
    #1 checkOutput("simul awvalid latency", m.awvalid, 1'b0);
    applyStimulus(1);
    writeTxn(0, 1, 30'h100, 32'hA0, "simul p0");
    applyStimulus(1);
    writeTxn(1, 1, 30'h200, 32'hB0, "simul p1");

    $display("[TB] single port-0 write burst");
    applyStimulus(1);
    setAw(0, 1, 30'h300, 8'd3, 4'd4);
    #1;
    checkOutput("single awvalid latency", m.awvalid, 1'b0);
    checkOutput("single grant latency", wr_grant_o, 2'b00);
    applyStimulus(1);
    writeTxn(0, 4, 30'h300, 32'h11, "single");

    $display("[TB] repeated simultaneous writes");
    applyStimulus(1);
    setAw(0, 1, 30'h500, 8'd0, 4'd5);
    setAw(1, 1, 30'h600, 8'd0, 4'd6);
    applyStimulus(1);
    writeTxn(1, 1, 30'h600, 32'hC0, "repeat p1");
    applyStimulus(1);
    writeTxn(0, 1, 30'h500, 32'hD0, "repeat p0");

    $display("[TB] concurrent write and read");
    applyStimulus(1);
    setAw(0, 1, 30'h700, 8'd7, 4'd1);
    setAr(1, 1, 30'h800, 8'd7, 4'd2);
    applyStimulus(1);
    #1;
    checkOutput("conc wgrant", wr_grant_o, 2'b01);
    checkOutput("conc rgrant", rd_grant_o, 2'b10);
    checkOutput("conc awvalid", m.awvalid, 1'b1);
    checkOutput("conc arvalid", m.arvalid, 1'b1);
    checkOutput("conc araddr", m.araddr, 30'h800);
    checkOutput("conc s0 arready", s0.arready, 1'b0);
    applyStimulus(1);
    setAw(0, 0, 0, 0, 0);
    setAr(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      setW(0, 1, 32'h1000 + i, i == 7);
      m.rvalid = 1; m.rdata = 32'h2000 + i; m.rlast = (i == 7); m.rid = 4'd2;
      #1;
      checkOutput("conc wdata", m.wdata, 32'h1000 + i);
      checkOutput("conc s1 rdata", s1.rdata, 32'h2000 + i);
      checkOutput("conc s0 rvalid", s0.rvalid, 1'b0);
      checkOutput("conc s0 rdata", s0.rdata, 32'h0);
      applyStimulus(1);
    end
    setW(0, 0, 0, 0);
    m.rvalid = 0; m.rlast = 0;
    m.bvalid = 1; m.bid = 4'd1;
    #1;
    checkOutput("conc rgrant done", rd_grant_o, 2'b00);
    checkOutput("conc s0 bvalid", s0.bvalid, 1'b1);
    applyStimulus(1);
    m.bvalid = 0;
    #1 checkOutput("conc wgrant done", wr_grant_o, 2'b00);

    $display("[TB] backpressure ordering");
    applyStimulus(1);
    setAw(0, 1, 30'h900, 8'd3, 4'd1);
    setAr(1, 1, 30'hA00, 8'd3, 4'd2);
    applyStimulus(2);
    setAw(0, 0, 0, 0, 0);
    setAr(1, 0, 0, 0, 0);
    wi = 0; ri = 0;
    for (int cyc = 0; cyc < 40 && (wi < 4 || ri < 4); cyc++) begin
      logic wFire, rFire;
      m.wready = (cyc % 2 == 1);
      setW(0, wi < 4, 32'h3000 + wi, wi == 3);
      m.rvalid = (ri < 4); m.rdata = 32'h4000 + ri; m.rlast = (ri == 3);
      s1.rready = (cyc % 3 != 0);
      #1;
      if (m.wvalid && m.wready) wGot.push_back(m.wdata);
      if (s1.rvalid && s1.rready) rGot.push_back(s1.rdata);
      wFire = s0.wvalid && s0.wready;
      rFire = m.rvalid && m.rready;
      applyStimulus(1);
      if (wFire) wi++;
      if (rFire) ri++;
    end
    checkOutput("bp completed in budget", (wi == 4) && (ri == 4), 1'b1);
    checkOutput("bp write beats", wGot.size(), 4);
    checkOutput("bp read beats", rGot.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wGot.size()) checkOutput("bp write order", wGot[i], 32'h3000 + i);
      if (i < rGot.size()) checkOutput("bp read order", rGot[i], 32'h4000 + i);
    end
    setW(0, 0, 0, 0);
    m.wready = 1; m.rvalid = 0; m.rlast = 0; s1.rready = 1;
    m.bvalid = 1;
    applyStimulus(1);
    m.bvalid = 0;
    #1;
    checkOutput("bp wgrant done", wr_grant_o, 2'b00);
    checkOutput("bp rgrant done", rd_grant_o, 2'b00);

    $display("[TB] reset during read burst");
    applyStimulus(1);
    setAr(1, 1, 30'hB00, 8'd7, 4'd5);
    applyStimulus(2);
    setAr(1, 0, 0, 0, 0);
    m.rvalid = 1; m.rlast = 0;
    for (int i = 0; i < 2; i++) begin
      m.rdata = 32'h5000 + i;
      applyStimulus(1);
    end
    m.rdata = 32'h5002;
    #1 checkOutput("mid s1 rdata", s1.rdata, 32'h5002);
    #1 rstn_i = 1'b0;
    #1;
    checkOutput("async rst rgrant", rd_grant_o, 2'b00);
    checkOutput("async rst s1 rvalid", s1.rvalid, 1'b0);
    checkOutput("async rst s1 rdata", s1.rdata, 32'h0);
    checkOutput("async rst rready", m.rready, 1'b0);
    m.rvalid = 0;
    applyStimulus(1);
    rstn_i = 1'b1;
    applyStimulus(1);
    setAr(1, 1, 30'hC00, 8'd0, 4'd6);
    #1 checkOutput("post rst rgrant latency", rd_grant_o, 2'b00);
    applyStimulus(1);
    #1;
    checkOutput("post rst rgrant", rd_grant_o, 2'b10);
    checkOutput("post rst arvalid", m.arvalid, 1'b1);
    checkOutput("post rst araddr", m.araddr, 30'hC00);
    checkOutput("post rst arid", m.arid, 4'd6);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
